// File: rtl/mem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and default constants for the block memory
//               (fetch FSM state encoding, block geometry, counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int DEF_ADDRESS_LEN = 15;
  localparam int DEF_WORD_LEN    = 32;
  localparam int DEF_MEM_LATENCY = 4;
  localparam int BLOCK_WORDS     = 4;
  // Latency counter width; covers the full 1..15 latency range.
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Word-addressed storage with one synchronous write port and a
//               combinational four-word block read port. No reset: contents
//               are only ever loaded through the write port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDRESS_LEN = DEF_ADDRESS_LEN,
  parameter int WORD_LEN    = DEF_WORD_LEN
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [ADDRESS_LEN-1:0]          wr_addr,
  input  logic [WORD_LEN-1:0]             wr_data,
  input  logic [ADDRESS_LEN-1:0]          rd_base,
  output logic [BLOCK_WORDS*WORD_LEN-1:0] rd_block
);

  localparam int c_depth = 2 ** ADDRESS_LEN;

  logic [WORD_LEN-1:0] r_mem [c_depth];

  // Single-word write, accepted in every FSM state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // rd_base is block aligned, so base+k never carries out of the address.
  genvar k;
  generate
    for (k = 0; k < BLOCK_WORDS; k++) begin : g_rd_word
      assign rd_block[k*WORD_LEN +: WORD_LEN] = r_mem[rd_base + ADDRESS_LEN'(k)];
    end
  endgenerate

endmodule : mem_array
`default_nettype wire

// File: rtl/block_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : block_memory
// Description : Backing memory for a cache. A level-sensitive request is
//               accepted in IDLE, a programmable latency elapses in FETCH,
//               the four-word block is captured, and a one-cycle ready pulse
//               announces it. A single-word write port preloads / stores.
// Revision    : 1.0 - initial release
// ============================================================================
module block_memory
  import mem_pkg::*;
#(
  parameter int ADDRESS_LEN = DEF_ADDRESS_LEN,
  parameter int WORD_LEN    = DEF_WORD_LEN,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req,
  input  logic [ADDRESS_LEN-1:0]          address,
  input  logic                            wr_en,
  input  logic [ADDRESS_LEN-1:0]          wr_addr,
  input  logic [WORD_LEN-1:0]             wr_data,
  output logic [BLOCK_WORDS*WORD_LEN-1:0] block_out,
  output logic                            ready,
  output logic                            busy
);

  localparam logic [ADDRESS_LEN-1:0] c_align_mask = ~ADDRESS_LEN'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]       c_lat_load   = CNT_W'(MEM_LATENCY - 1);

  state_t                          r_state;
  state_t                          w_next_state;
  logic [CNT_W-1:0]                r_cnt;
  logic [ADDRESS_LEN-1:0]          r_base;
  logic [BLOCK_WORDS*WORD_LEN-1:0] r_block;
  logic [BLOCK_WORDS*WORD_LEN-1:0] w_rd_block;
  logic                            r_ready;
  logic                            w_accept;
  logic                            w_capture;
  logic                            w_busy;

  // Storage; the read port always looks at the latched block base.
  mem_array #(
    .ADDRESS_LEN (ADDRESS_LEN),
    .WORD_LEN    (WORD_LEN)
  ) u_mem_array (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_base  (r_base),
    .rd_block (w_rd_block)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus accept/capture strobes and busy.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept     = 1'b1;
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        w_busy = 1'b1;
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_busy       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Base latch, latency counter, block capture and the registered ready.
  // ready is registered off RESP so it lands MEM_LATENCY+1 edges after accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_base  <= '0;
      r_block <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (r_state == RESP);
      if (w_accept) begin
        r_base <= address & c_align_mask;
        r_cnt  <= c_lat_load;
      end else if ((r_state == FETCH) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_block <= w_rd_block;
      end
    end
  end

  assign block_out = r_block;
  assign ready     = r_ready;
  assign busy      = w_busy;

endmodule : block_memory
`default_nettype wire

// File: tb/tb_block_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_block_memory
// Description : Self-checking bench for block_memory: a spec-level model
//               predicts each fetched block and its ready cycle into a
//               scoreboard; a negedge monitor compares whenever ready pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_memory;

  localparam int AW   = 15;
  localparam int WL   = 32;
  localparam int LAT  = 4;
  localparam int LAT1 = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           req = 1'b0, req1 = 1'b0;
  logic [AW-1:0]  address = '0, address1 = '0;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [WL-1:0]  wr_data = '0;
  logic [4*WL-1:0] block_out, block_out1;
  logic           ready, ready1, busy, busy1;

  always #5 clk = ~clk;

  block_memory #(.ADDRESS_LEN(AW), .WORD_LEN(WL), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .address(address),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .block_out(block_out), .ready(ready), .busy(busy)
  );

  block_memory #(.ADDRESS_LEN(AW), .WORD_LEN(WL), .MEM_LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .address(address1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .block_out(block_out1), .ready(ready1), .busy(busy1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct { logic [4*WL-1:0] blk; int cyc; } exp_t;
  exp_t sb[$];

  // Reference model of the latency-LAT instance.
  logic [WL-1:0]   m_mem [0:32767];
  int              m_cnt  = -1;   // edges since accept, -1 when idle
  logic [AW-1:0]   m_base = '0;
  logic [4*WL-1:0] m_blk  = '0;
  logic            m_busy = 1'b0;
  int              cyc    = 0;

  task automatic chk(input string name, input logic [4*WL-1:0] act, input logic [4*WL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*WL-1:0] model_blk(input logic [AW-1:0] a);
    logic [4*WL-1:0] r;
    logic [AW-1:0]   b;
    b = a & 15'h7FFC;
    for (int k = 0; k < 4; k++) r[k*WL +: WL] = m_mem[b + AW'(k)];
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt  = -1;
      m_blk  = '0;
      m_busy = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      if (m_cnt < 0) begin
        if (req) begin
          m_base = address & 15'h7FFC;
          m_cnt  = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_blk = model_blk(m_base);   // contents before this edge's write
          sb.push_back('{m_blk, cyc + 1});
        end else if (m_cnt == LAT + 1) begin
          m_cnt = -1;
        end
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
      m_busy = (m_cnt >= 0);
    end
  end

  // Monitor: busy and held block every cycle; scoreboard pop on ready.
  always @(negedge clk) begin
    exp_t e;
    chk("busy", 128'(busy), 128'(m_busy));
    chk("block_hold", block_out, m_blk);
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_missing: got no ready expected ready at cycle %0d", sb[0].cyc);
      void'(sb.pop_front());
    end
    if (ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ready_unexpected: got ready at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("sb_block", block_out, e.blk);
        chk("sb_ready_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [WL-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, input logic [AW-1:0] alt, input bit cap_wr,
                          input logic [AW-1:0] wa, input logic [WL-1:0] wd,
                          output logic [4*WL-1:0] blk);
    int seen;
    seen = -1;
    blk  = '0;
    req = 1'b1; address = a;
    @(negedge clk);
    req = 1'b0; address = alt;
    repeat (LAT - 1) @(negedge clk);
    if (cap_wr) begin
      wr_en = 1'b1; wr_addr = wa; wr_data = wd;
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = i;
        blk  = block_out;
        break;
      end
    end
    chk("fetch_latency", 128'(seen), 128'(0));
  endtask

  initial begin
    logic [4*WL-1:0] blk;
    int lows, rdys;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_ready", 128'(ready), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_block", block_out, '0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 256; a++) wr(AW'(a), $urandom);
    for (int a = 32764; a < 32768; a++) wr(AW'(a), $urandom);
    wr(15'h0010, 32'h11); wr(15'h0011, 32'h22); wr(15'h0012, 32'h33); wr(15'h0013, 32'h44);

    // Basic fetch of block 0x0010.
    do_fetch(15'h0012, 15'h0012, 1'b0, '0, '0, blk);
    chk("fetch_0x12", blk, 128'h00000044_00000033_00000022_00000011);

    // Address moved during FETCH is ignored.
    do_fetch(15'h0012, 15'h7FFC, 1'b0, '0, '0, blk);
    chk("addr_change_ignored", blk, 128'h00000044_00000033_00000022_00000011);

    // Write on the capture edge is not seen; the refetch sees it.
    do_fetch(15'h0012, 15'h0012, 1'b1, 15'h0011, 32'hDEAD, blk);
    chk("capture_write_old", 128'(blk[63:32]), 128'(32'h22));
    do_fetch(15'h0011, 15'h0011, 1'b0, '0, '0, blk);
    chk("refetch_new", blk, 128'h00000044_00000033_0000DEAD_00000011);

    // Top block on the long-latency instance.
    do_fetch(15'h7FFD, 15'h0, 1'b0, '0, '0, blk);
    chk("top_block", blk, model_blk(15'h7FFC));

    // Latency 1: ready two edges after accept, top block.
    req1 = 1'b1; address1 = 15'h7FFC;
    @(negedge clk);
    req1 = 1'b0;
    chk("lat1_busy", 128'(busy1), 128'(1));
    chk("lat1_ready_e1", 128'(ready1), 128'(0));
    @(negedge clk);
    chk("lat1_ready_e1b", 128'(ready1), 128'(0));
    @(negedge clk);
    chk("lat1_ready_e2", 128'(ready1), 128'(1));
    chk("lat1_block", block_out1, model_blk(15'h7FFC));
    @(negedge clk);

    // req held high for two fills: one idle cycle between, two ready pulses.
    lows = 0; rdys = 0;
    req = 1'b1; address = 15'h0012;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 11) req = 1'b0;
      if (i < 11 && !busy) lows++;
      if (ready) rdys++;
    end
    chk("b2b_idle_cycles", 128'(lows), 128'(1));
    chk("b2b_ready_pulses", 128'(rdys), 128'(2));

    // Reset mid-FETCH: outputs cleared at once, no ready, memory kept.
    req = 1'b1; address = 15'h0012;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_ready", 128'(ready), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_block", block_out, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    rdys = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready) rdys++;
    end
    chk("abort_no_ready", 128'(rdys), 128'(0));
    do_fetch(15'h0010, 15'h0010, 1'b0, '0, '0, blk);
    chk("mem_preserved", blk, 128'h00000044_00000033_0000DEAD_00000011);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      req     = ($urandom_range(0, 3) == 0);
      address = AW'($urandom_range(0, 255));
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, 255));
      wr_data = $urandom;
      if (i == 250) begin
        req = 1'b0; wr_en = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    req = 1'b0; wr_en = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_block_memory
`default_nettype wire

// File: doc/block_memory.md
BLOCK_MEMORY -- requirements
Module: block_memory

Interface
REQ-001 SHALL have parameter ADDRESS_LEN, default 15: word-address width; matches cache address.
REQ-002 SHALL have parameter WORD_LEN, default 32: data word width.
REQ-003 SHALL have parameter MEM_LATENCY, default 4: cycles from request accept to ready; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req, input, 1 bit: block fetch request (driven by cache miss), level-sensitive.
REQ-007 SHALL have port address, input, ADDRESS_LEN bits: word address of the missing word.
REQ-008 SHALL have port wr_en, input, 1 bit: single-word write strobe (preload/store).
REQ-009 SHALL have port wr_addr, input, ADDRESS_LEN bits: write word address.
REQ-010 SHALL have port wr_data, input, WORD_LEN bits: write data.
REQ-011 SHALL have port block_out, output, 4*WORD_LEN bits: fetched block; word k occupies bits [32k+31:32k].
REQ-012 SHALL have port ready, output, 1 bit: one-cycle pulse; block_out valid for the cache fill.
REQ-013 SHALL have port busy, output, 1 bit: high while a fetch is in progress (FETCH or RESP).

Function
REQ-014 SHALL hold 2**ADDRESS_LEN words of WORD_LEN bits.
REQ-015 SHALL implement FSM states IDLE, FETCH, RESP.
REQ-016 IDLE with req=1 at a clock edge SHALL latch address[ADDRESS_LEN-1:2] as block base, load counter with MEM_LATENCY-1 and enter FETCH.
REQ-017 FETCH SHALL decrement the counter each cycle; at counter 0 the edge SHALL capture words base*4+0..3 into block_out and enter RESP.
REQ-018 RESP SHALL assert ready for exactly one cycle, then return to IDLE unconditionally.
REQ-019 ready SHALL rise exactly MEM_LATENCY+1 edges after the accepting edge; for MEM_LATENCY=1, FETCH lasts one cycle.
REQ-020 req and address changes during FETCH/RESP SHALL be ignored; the latched base governs the fetch.
REQ-021 req still high in IDLE on the cycle after RESP SHALL start a new fetch; the cache is responsible for dropping req after the fill.
REQ-022 wr_en=1 SHALL write wr_data to wr_addr at the edge in any state.
REQ-023 A write at the same edge as the block capture SHALL NOT appear in that block_out; block_out reflects pre-edge contents.
REQ-024 block_out SHALL hold its value until the next capture.
REQ-025 Address arithmetic SHALL be unsigned; base*4+3 never exceeds 2**ADDRESS_LEN-1 and needs no wrap.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, counter 0, block_out 0, ready 0 and busy 0, independent of clk.
REQ-027 Reset during FETCH or RESP SHALL abort the fetch, with no ready pulse after release.
REQ-028 Reset SHALL NOT clear the memory array; contents are loaded through the write port.
REQ-029 The first edge after rst rises SHALL be treated as a normal IDLE cycle.

Structure
REQ-030 A shared package mem_pkg SHALL hold the state enum (IDLE, FETCH, RESP), BLOCK_WORDS=4 and the default WORD_LEN, ADDRESS_LEN and MEM_LATENCY constants.
REQ-031 Storage SHALL be a sub-module mem_array with a one-word write port and a combinational four-word block read port.
REQ-032 The FSM, counter and block register SHALL reside in block_memory.

Verification
REQ-033 Scenario: write 0x11,0x22,0x33,0x44 to 0x0010..0x0013; pulse req with address 0x0012 -> ready exactly 5 edges later with block_out=0x00000044_00000033_00000022_00000011.
REQ-034 Scenario: hold req high through the fill, then drop it -> back-to-back fetches only while req is high; busy low exactly one cycle between fetches.
REQ-035 Scenario: change address from 0x0012 to 0x7FFC during FETCH -> block from 0x0010 returned.
REQ-036 Scenario: write 0xDEAD to 0x0011 on the capture edge -> word1 keeps its old value 0x22; a refetch returns 0xDEAD.
REQ-037 Scenario: rst=0 mid-FETCH for 1 cycle -> ready never pulses, outputs 0, memory contents preserved.
REQ-038 Scenario: MEM_LATENCY=1, req at top block 0x7FFC -> ready 2 edges later with words 0x7FFC..0x7FFF.
